// File: rtl/flit_transmitter_pkg.sv
// Shared types and HEAD flit layout for the flit transmitter.
// HEAD word: {dst, src, len, seq}, one byte each, in bits [31:0].
package flit_transmitter_pkg;

  localparam int NODE_ID_W    = 8;
  localparam int SEQ_W        = 8;
  localparam int HEAD_W       = 32;
  localparam int HEAD_FIELD_W = 8;
  localparam int HEAD_SEQ_LSB = 0;
  localparam int HEAD_LEN_LSB = 8;
  localparam int HEAD_SRC_LSB = 16;
  localparam int HEAD_DST_LSB = 24;

  typedef enum logic [1:0] {
    FLIT_NONE = 2'd0,
    FLIT_HEAD = 2'd1,
    FLIT_BODY = 2'd2,
    FLIT_TAIL = 2'd3
  } flit_type_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HEAD = 2'd1,
    ST_BODY = 2'd2,
    ST_TAIL = 2'd3
  } tx_state_t;

  function automatic logic [HEAD_W-1:0] head_word(
    input logic [NODE_ID_W-1:0]    dst,
    input logic [NODE_ID_W-1:0]    src,
    input logic [HEAD_FIELD_W-1:0] len,
    input logic [SEQ_W-1:0]        seq
  );
    logic [HEAD_W-1:0] w;
    w = '0;
    w[HEAD_DST_LSB +: NODE_ID_W]    = dst;
    w[HEAD_SRC_LSB +: NODE_ID_W]    = src;
    w[HEAD_LEN_LSB +: HEAD_FIELD_W] = len;
    w[HEAD_SEQ_LSB +: SEQ_W]        = seq;
    return w;
  endfunction

endpackage

// File: rtl/flit_transmitter_if.sv
// Header, payload and flit-link handshakes of the flit transmitter.
// master = transmitter side, slave = packet source / flit sink side.
interface flit_transmitter_if #(
  parameter int FLIT_W   = 32,
  parameter int MAX_BODY = 8
);
  import flit_transmitter_pkg::*;

  localparam int LEN_W = $clog2(MAX_BODY + 1);

  logic                 pkt_valid;
  logic                 pkt_ready;
  logic [NODE_ID_W-1:0] pkt_src_id;
  logic [NODE_ID_W-1:0] pkt_dst_id;
  logic [LEN_W-1:0]     pkt_len;
  logic                 pld_valid;
  logic                 pld_ready;
  logic [FLIT_W-1:0]    pld_data;
  logic                 flit_valid;
  logic                 flit_ready;
  flit_type_t           flit_type;
  logic [FLIT_W-1:0]    flit_data;
  logic                 len_err;

  modport master (
    input  pkt_valid, pkt_src_id, pkt_dst_id, pkt_len,
    input  pld_valid, pld_data, flit_ready,
    output pkt_ready, pld_ready, flit_valid, flit_type, flit_data, len_err
  );

  modport slave (
    output pkt_valid, pkt_src_id, pkt_dst_id, pkt_len,
    output pld_valid, pld_data, flit_ready,
    input  pkt_ready, pld_ready, flit_valid, flit_type, flit_data, len_err
  );

endinterface

// File: rtl/flit_checksum.sv
// Running XOR of the BODY words of the packet in flight; its value becomes the TAIL data.
module flit_checksum #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_clear,
  input  logic              i_accum,
  input  logic [DATA_W-1:0] i_data,
  output logic [DATA_W-1:0] o_sum
);

  logic [DATA_W-1:0] r_sum;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sum <= '0;
    end else if (i_clear) begin
      r_sum <= '0;
    end else if (i_accum) begin
      r_sum <= r_sum ^ i_data;
    end
  end

  assign o_sum = r_sum;

endmodule

// File: rtl/flit_transmitter.sv
// Packet-to-flit transmitter: one header + payload stream -> HEAD, BODY..., TAIL flits.
// Define FLIT_TX_CHECKSUM_EN to carry the XOR of the BODY words in the TAIL flit.
module flit_transmitter
  import flit_transmitter_pkg::*;
#(
  parameter int FLIT_W   = 32,
  parameter int MAX_BODY = 8
) (
  input  logic              clk,
  input  logic              rst,
  flit_transmitter_if.master bus
);

  localparam int               LEN_W   = $clog2(MAX_BODY + 1);
  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_BODY);

  tx_state_t         r_state;
  tx_state_t         w_state_next;
  logic              r_run;
  logic [LEN_W-1:0]  r_len;
  logic [LEN_W-1:0]  r_body_cnt;
  logic [SEQ_W-1:0]  r_seq;
  logic              r_flit_valid;
  flit_type_t        r_flit_type;
  logic [FLIT_W-1:0] r_flit_data;
  logic              r_len_err;

  logic              w_flit_accept;
  logic              w_slot_free;
  logic              w_tail_done;
  logic              w_pkt_ready;
  logic              w_pld_ready;
  logic              w_len_bad;
  logic              w_load_head;
  logic              w_load_body;
  logic              w_load_tail;
  logic [SEQ_W-1:0]  w_head_seq;
  logic [FLIT_W-1:0] w_tail_data;

  assign w_flit_accept = r_flit_valid && bus.flit_ready;
  assign w_slot_free   = !r_flit_valid || bus.flit_ready;
  assign w_tail_done   = (r_state == ST_TAIL) && w_flit_accept;
  // A header taken while the previous TAIL leaves must already carry the bumped sequence.
  assign w_head_seq    = w_tail_done ? r_seq + SEQ_W'(1) : r_seq;

  always_comb begin
    w_state_next = r_state;
    w_pkt_ready  = 1'b0;
    w_pld_ready  = 1'b0;
    w_len_bad    = 1'b0;
    w_load_head  = 1'b0;
    w_load_body  = 1'b0;
    w_load_tail  = 1'b0;
    case (r_state)
      ST_IDLE: w_pkt_ready = r_run;
      ST_HEAD: begin
        if (w_flit_accept) begin
          if (r_len == '0) begin
            w_load_tail  = 1'b1;
            w_state_next = ST_TAIL;
          end else begin
            w_state_next = ST_BODY;
          end
        end
      end
      ST_BODY: begin
        w_pld_ready = w_slot_free && (r_body_cnt < r_len);
        if (w_pld_ready && bus.pld_valid) begin
          w_load_body = 1'b1;
        end else if ((r_body_cnt == r_len) && w_flit_accept) begin
          w_load_tail  = 1'b1;
          w_state_next = ST_TAIL;
        end
      end
      ST_TAIL: begin
        if (w_flit_accept) begin
          w_pkt_ready  = 1'b1;
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
    if (w_pkt_ready && bus.pkt_valid) begin
      if (bus.pkt_len > MAX_LEN) begin
        w_len_bad = 1'b1;
      end else begin
        w_load_head  = 1'b1;
        w_state_next = ST_HEAD;
      end
    end
  end

`ifdef FLIT_TX_CHECKSUM_EN
  logic [FLIT_W-1:0] w_checksum;

  flit_checksum #(
    .DATA_W (FLIT_W)
  ) u_checksum (
    .clk     (clk),
    .rst     (rst),
    .i_clear (w_load_head),
    .i_accum (w_load_body),
    .i_data  (bus.pld_data),
    .o_sum   (w_checksum)
  );

  assign w_tail_data = w_checksum;
`else
  assign w_tail_data = '0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_run        <= 1'b0;
      r_len        <= '0;
      r_body_cnt   <= '0;
      r_seq        <= '0;
      r_flit_valid <= 1'b0;
      r_flit_type  <= FLIT_NONE;
      r_flit_data  <= '0;
      r_len_err    <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_run     <= 1'b1;
      r_len_err <= w_len_bad;
      if (w_tail_done) begin
        r_seq <= r_seq + SEQ_W'(1);
      end
      if (w_load_head) begin
        r_len      <= bus.pkt_len;
        r_body_cnt <= '0;
      end else if (w_load_body) begin
        r_body_cnt <= r_body_cnt + LEN_W'(1);
      end
      // Output slot: loads only when empty or draining; otherwise holds its flit.
      if (w_load_head) begin
        r_flit_valid <= 1'b1;
        r_flit_type  <= FLIT_HEAD;
        r_flit_data  <= FLIT_W'(head_word(bus.pkt_dst_id, bus.pkt_src_id,
                                          HEAD_FIELD_W'(bus.pkt_len), w_head_seq));
      end else if (w_load_body) begin
        r_flit_valid <= 1'b1;
        r_flit_type  <= FLIT_BODY;
        r_flit_data  <= bus.pld_data;
      end else if (w_load_tail) begin
        r_flit_valid <= 1'b1;
        r_flit_type  <= FLIT_TAIL;
        r_flit_data  <= w_tail_data;
      end else if (w_flit_accept) begin
        r_flit_valid <= 1'b0;
        r_flit_type  <= FLIT_NONE;
        r_flit_data  <= '0;
      end
    end
  end

  assign bus.pkt_ready  = w_pkt_ready;
  assign bus.pld_ready  = w_pld_ready;
  assign bus.flit_valid = r_flit_valid;
  assign bus.flit_type  = r_flit_type;
  assign bus.flit_data  = r_flit_data;
  assign bus.len_err    = r_len_err;

endmodule

// File: tb/tb_flit_transmitter.sv
// Directed bench for flit_transmitter; TAIL expectations follow FLIT_TX_CHECKSUM_EN.
`timescale 1ns/1ps
module tb_flit_transmitter;

  localparam int FLIT_W   = 32;
  localparam int MAX_BODY = 8;

  localparam logic [1:0] T_NONE = 2'd0;
  localparam logic [1:0] T_HEAD = 2'd1;
  localparam logic [1:0] T_BODY = 2'd2;
  localparam logic [1:0] T_TAIL = 2'd3;

`ifdef FLIT_TX_CHECKSUM_EN
  localparam logic [31:0] T2_TAIL  = 32'hA5A5_00FE;
  localparam logic [31:0] T4_TAIL2 = 32'h1234_5678;
`else
  localparam logic [31:0] T2_TAIL  = 32'h0000_0000;
  localparam logic [31:0] T4_TAIL2 = 32'h0000_0000;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  flit_transmitter_if #(.FLIT_W(FLIT_W), .MAX_BODY(MAX_BODY)) bus ();

  flit_transmitter #(.FLIT_W(FLIT_W), .MAX_BODY(MAX_BODY)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic [33:0] got_q[$];
  int          got_cyc[$];
  logic        stall_mode = 1'b0;
  int          stall_cnt = 0;
  logic        hold_pending = 1'b0;
  logic [34:0] hold_word = '0;

  task automatic chk(input string tag, input logic [35:0] obs, input logic [35:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_flit(input string tag, input int idx, input logic [1:0] ty, input logic [31:0] data);
    chk(tag, 36'(got_q[idx]), 36'({ty, data}));
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Flit sink: accepted flits are logged; a stalled flit must look identical one cycle later.
  always @(negedge clk) begin
    if (rst) begin
      hold_pending = 1'b0;
    end else begin
      if (hold_pending)
        chk("hold_stable", 36'({bus.flit_valid, bus.flit_type, bus.flit_data}), 36'(hold_word));
      if (bus.flit_valid && bus.flit_ready) begin
        got_q.push_back({bus.flit_type, bus.flit_data});
        got_cyc.push_back(cyc);
      end
      hold_pending = bus.flit_valid && !bus.flit_ready;
      hold_word    = {bus.flit_valid, bus.flit_type, bus.flit_data};
    end
  end

  initial begin
    bus.flit_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (!stall_mode) begin
        bus.flit_ready = 1'b1;
      end else if (!bus.flit_valid) begin
        bus.flit_ready = 1'b0;
        stall_cnt = 0;
      end else if (stall_cnt < 3) begin
        bus.flit_ready = 1'b0;
        stall_cnt++;
      end else begin
        bus.flit_ready = 1'b1;
        stall_cnt = 0;
      end
    end
  end

  task automatic offer_header(input logic [7:0] src, input logic [7:0] dst, input logic [3:0] len);
    logic done;
    done = 1'b0;
    bus.pkt_src_id = src;
    bus.pkt_dst_id = dst;
    bus.pkt_len    = len;
    bus.pkt_valid  = 1'b1;
    for (int n = 0; n < 64 && !done; n++) begin
      #1;
      done = bus.pkt_ready;
      @(posedge clk); #1;
    end
    bus.pkt_valid = 1'b0;
    chk("hdr_accept", 36'(done), 36'd1);
  endtask

  task automatic offer_word(input logic [31:0] data);
    logic done;
    done = 1'b0;
    bus.pld_data  = data;
    bus.pld_valid = 1'b1;
    for (int n = 0; n < 64 && !done; n++) begin
      #1;
      done = bus.pld_ready;
      @(posedge clk); #1;
    end
    bus.pld_valid = 1'b0;
    chk("pld_accept", 36'(done), 36'd1);
  endtask

  task automatic wait_flits(input string tag, input int n);
    for (int k = 0; k < 400 && got_q.size() < n; k++) begin
      @(posedge clk); #1;
    end
    repeat (4) begin
      @(posedge clk); #1;
    end
    chk(tag, 36'(got_q.size()), 36'(n));
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    bus.pkt_valid = 1'b0;
    bus.pld_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    got_q.delete();
    got_cyc.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int tails;
    rst = 1'b1;
    bus.pkt_valid  = 1'b0;
    bus.pkt_src_id = '0;
    bus.pkt_dst_id = '0;
    bus.pkt_len    = '0;
    bus.pld_valid  = 1'b0;
    bus.pld_data   = '0;

    // 1: reset values, then pkt_ready rises one cycle after release
    repeat (2) @(posedge clk);
    #2;
    chk("rst_pkt_ready", 36'(bus.pkt_ready), 36'd0);
    chk("rst_pld_ready", 36'(bus.pld_ready), 36'd0);
    chk("rst_flit_valid", 36'(bus.flit_valid), 36'd0);
    chk("rst_flit_type", 36'(bus.flit_type), 36'(T_NONE));
    chk("rst_flit_data", 36'(bus.flit_data), 36'd0);
    chk("rst_len_err", 36'(bus.len_err), 36'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("rel_pkt_ready_same", 36'(bus.pkt_ready), 36'd0);
    @(posedge clk); #1;
    chk("rel_pkt_ready_next", 36'(bus.pkt_ready), 36'd1);
    got_q.delete();
    got_cyc.delete();

    // 2: basic packet, len=2
    offer_header(8'h03, 8'h05, 4'd2);
    offer_word(32'hA5A5_0001);
    offer_word(32'h0000_00FF);
    wait_flits("t2_count", 4);
    chk_flit("t2_head", 0, T_HEAD, 32'h0503_0200);
    chk_flit("t2_body0", 1, T_BODY, 32'hA5A5_0001);
    chk_flit("t2_body1", 2, T_BODY, 32'h0000_00FF);
    chk_flit("t2_tail", 3, T_TAIL, T2_TAIL);

    // 3: same packet with three stall cycles on every flit
    apply_reset();
    stall_mode = 1'b1;
    offer_header(8'h03, 8'h05, 4'd2);
    offer_word(32'hA5A5_0001);
    offer_word(32'h0000_00FF);
    wait_flits("t3_count", 4);
    stall_mode = 1'b0;
    chk_flit("t3_head", 0, T_HEAD, 32'h0503_0200);
    chk_flit("t3_body0", 1, T_BODY, 32'hA5A5_0001);
    chk_flit("t3_body1", 2, T_BODY, 32'h0000_00FF);
    chk_flit("t3_tail", 3, T_TAIL, T2_TAIL);
    chk("t3_stalled", 36'((got_cyc[3] - got_cyc[0]) >= 12), 36'd1);

    // 4: len=0 then len=1 back to back
    apply_reset();
    offer_header(8'h0A, 8'h0B, 4'd0);
    offer_header(8'h0A, 8'h0B, 4'd1);
    offer_word(32'h1234_5678);
    wait_flits("t4_count", 5);
    chk_flit("t4_head0", 0, T_HEAD, 32'h0B0A_0000);
    chk_flit("t4_tail0", 1, T_TAIL, 32'h0000_0000);
    chk_flit("t4_head1", 2, T_HEAD, 32'h0B0A_0101);
    chk_flit("t4_body1", 3, T_BODY, 32'h1234_5678);
    chk_flit("t4_tail1", 4, T_TAIL, T4_TAIL2);
    chk("t4_gap_head_tail", 36'(got_cyc[1] - got_cyc[0]), 36'd1);
    chk("t4_gap_tail_head", 36'(got_cyc[2] - got_cyc[1]), 36'd1);
    chk("t4_gap_body_tail", 36'(got_cyc[4] - got_cyc[3]), 36'd1);

    // 5: oversize header dropped with len_err pulse; seq untouched
    got_q.delete();
    got_cyc.delete();
    offer_header(8'h07, 8'h09, 4'd9);
    #1;
    chk("t5_len_err_pulse", 36'(bus.len_err), 36'd1);
    chk("t5_no_flit", 36'(bus.flit_valid), 36'd0);
    @(posedge clk); #2;
    chk("t5_len_err_clear", 36'(bus.len_err), 36'd0);
    chk("t5_nothing_sent", 36'(got_q.size()), 36'd0);
    @(posedge clk); #1;
    offer_header(8'h07, 8'h09, 4'd0);
    wait_flits("t5_count", 2);
    chk_flit("t5_head", 0, T_HEAD, 32'h0907_0002);
    chk_flit("t5_tail", 1, T_TAIL, 32'h0000_0000);

    // 6a: 257 empty packets, sequence wraps after 255
    apply_reset();
    for (int i = 0; i < 257; i++) offer_header(8'h11, 8'h22, 4'd0);
    wait_flits("t6_count", 514);
    for (int i = 0; i < 257; i++) begin
      logic [7:0] s;
      s = 8'(i);
      chk_flit($sformatf("t6_head%0d", i), 2 * i, T_HEAD, {8'h22, 8'h11, 8'h00, s});
    end
    chk_flit("t6_tail_last", 513, T_TAIL, 32'h0000_0000);

    // 6b: reset in the middle of BODY abandons the packet
    apply_reset();
    offer_header(8'h01, 8'h02, 4'd3);
    offer_word(32'hDEAD_BEEF);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("t6_rst_flit_valid", 36'(bus.flit_valid), 36'd0);
    chk("t6_rst_flit_type", 36'(bus.flit_type), 36'(T_NONE));
    chk("t6_rst_pld_ready", 36'(bus.pld_ready), 36'd0);
    chk("t6_rst_pkt_ready", 36'(bus.pkt_ready), 36'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("t6_rel_pkt_ready", 36'(bus.pkt_ready), 36'd1);
    repeat (8) begin
      @(posedge clk); #1;
    end
    tails = 0;
    foreach (got_q[k]) if (got_q[k][33:32] == T_TAIL) tails++;
    chk("t6_no_tail", 36'(tails), 36'd0);
    chk("t6_idle_after_rst", 36'(bus.flit_valid), 36'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
